roulette_round_ctrl: RTL

Round sequencer for the roulette games. Owns the shared player balance, edge-detects the spin button, runs a fixed-length spin window sampling the free-running random source, then evaluates the latched number against the player's guess in one of two modes (even/odd or exact number). It applies the payout and moves the game into its win or lose terminal state. It sits between the board inputs (switches/keys), the LFSR, and the HEX/LED display logic.

---
 rtl/roulette_round_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/roulette_round_ctrl.sv
// Roulette round sequencer: press edge detect, spin window, evaluation and balance/payout.
// Optional `ROULETTE_GREEN_ZERO_EN: a latched 0 loses in both game modes.
//
// state | meaning
// READY | idle, waiting for a fresh spin press
// SPIN  | sampling rand_in for SPIN_CYCLES cycles
// EVAL  | one cycle: score the latched number, apply payout
// WIN   | balance reached BAL_WIN, absorbing until reset
// LOSE  | balance reached 0, absorbing until reset
module roulette_round_ctrl #(
    parameter int SPIN_CYCLES = 16,
    parameter int BAL_W       = 5,
    parameter int BAL_INIT    = 10,
    parameter int BAL_WIN     = 20
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             spin_btn,
    input  logic             mode,
    input  logic [4:0]       guess,
    input  logic [4:0]       rand_in,
    output logic [4:0]       rand_latched,
    output logic [BAL_W-1:0] balance,
    output logic [2:0]       state_out,
    output logic             busy,
    output logic             result_valid,
    output logic             last_win,
    output logic             win_led,
    output logic             lose_led
);

    localparam logic [2:0] S_READY = 3'd0;
    localparam logic [2:0] S_SPIN  = 3'd1;
    localparam logic [2:0] S_EVAL  = 3'd2;
    localparam logic [2:0] S_WIN   = 3'd3;
    localparam logic [2:0] S_LOSE  = 3'd4;

    localparam logic [7:0]       CNT_LOAD  = 8'(SPIN_CYCLES - 1);
    localparam logic [BAL_W-1:0] BAL_RST   = BAL_W'(BAL_INIT);
    localparam logic [BAL_W-1:0] BAL_GOAL  = BAL_W'(BAL_WIN);
    localparam logic [BAL_W-1:0] PAY_EVEN  = BAL_W'(2);
    localparam logic [BAL_W-1:0] PAY_EXACT = BAL_W'(5);
    localparam logic [BAL_W-1:0] BAL_ONE   = BAL_W'(1);

    logic [2:0]       state;
    logic [7:0]       cnt;
    logic             btn_q;
    logic             press;
    logic             match;
    logic             win;
    logic [BAL_W-1:0] payout;
    logic [BAL_W-1:0] bal_next;

    always_comb begin
        press = btn_q && !spin_btn;
        if (mode)
            match = (rand_latched == guess);
        else
            match = (rand_latched[0] == ~guess[0]);
`ifdef ROULETTE_GREEN_ZERO_EN
        win = match && (rand_latched != 5'd0);
`else
        win = match;
`endif
        payout   = mode ? PAY_EXACT : PAY_EVEN;
        bal_next = win ? (balance + payout) : (balance - BAL_ONE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= S_READY;
            balance      <= BAL_RST;
            rand_latched <= 5'd0;
            cnt          <= 8'd0;
            result_valid <= 1'b0;
            last_win     <= 1'b0;
            btn_q        <= 1'b1;
        end else begin
            btn_q        <= spin_btn;
            result_valid <= 1'b0;
            case (state)
                S_READY: begin
                    if (press) begin
                        state <= S_SPIN;
                        cnt   <= CNT_LOAD;
                    end
                end
                S_SPIN: begin
                    // the value captured on the terminal-count cycle is the final draw
                    rand_latched <= rand_in;
                    if (cnt == 8'd0)
                        state <= S_EVAL;
                    else
                        cnt <= cnt - 8'd1;
                end
                S_EVAL: begin
                    balance      <= bal_next;
                    last_win     <= win;
                    result_valid <= 1'b1;
                    if (bal_next >= BAL_GOAL)
                        state <= S_WIN;
                    else if (bal_next == '0)
                        state <= S_LOSE;
                    else
                        state <= S_READY;
                end
                default: state <= state;
            endcase
        end
    end

    assign state_out = state;
    assign busy      = (state == S_SPIN) || (state == S_EVAL);
    assign win_led   = (state == S_WIN);
    assign lose_led  = (state == S_LOSE);

endmodule
